// File: rtl/d_mem_lsu.sv
// d_mem_lsu: load/store unit driving a word-aligned data-memory port.
// Does lane placement, byte enables, extension and word-crossing splits.
module d_mem_lsu #(
    parameter int WORD_WIDTH       = 32,
    parameter int ADRS_WIDTH       = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADRS_WIDTH-1:0] req_adrs,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WORD_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADRS_WIDTH-1:0] mem_adrs,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [3:0]            mem_byt_en,
    output logic                  mem_sign_ext,
    output logic [WORD_WIDTH-1:0] mem_wr_data,
    input  logic [WORD_WIDTH-1:0] mem_rd_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]            state;
    logic                  r_we;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic [ADRS_WIDTH-1:0] r_adrs;
    logic [WORD_WIDTH-1:0] r_wdata;
    logic [WORD_WIDTH-1:0] lo_buf;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        unique case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic crosses(input logic [1:0] off,
                                     input logic [1:0] sz);
        return ({1'b0, off} + size_bytes(sz)) > 3'd4;
    endfunction

    logic                    in_err;
    logic [1:0]              off;
    logic                    r_cross;
    logic [3:0]              fill;
    logic [7:0]              lane_mask;
    logic [2*WORD_WIDTH-1:0] wr_sh;
    logic [ADRS_WIDTH-1:0]   word0;
    logic [ADRS_WIDTH-1:0]   word1;
    logic [WORD_WIDTH-1:0]   lo_src;
    logic [2*WORD_WIDTH-1:0] rd_cat;
    logic [WORD_WIDTH-1:0]   rd_sh;
    logic [WORD_WIDTH-1:0]   load_val;

    assign in_err = (req_size == 2'b11) ||
                    (crosses(req_adrs[1:0], req_size) && !ALLOW_MISALIGNED);

    assign off     = r_adrs[1:0];
    assign r_cross = crosses(off, r_size);
    assign word0   = {r_adrs[ADRS_WIDTH-1:2], 2'b00};
    assign word1   = word0 + ADRS_WIDTH'(4);

    // Lane fill pattern for the access size, before shifting to the offset
    always_comb begin
        fill = 4'b1111;
        unique case (r_size)
            2'b00:   fill = 4'b0001;
            2'b01:   fill = 4'b0011;
            default: fill = 4'b1111;
        endcase
    end

    // Low nibble/word feeds ACC0, high nibble/word feeds ACC1
    assign lane_mask = {4'b0000, fill} << off;
    assign wr_sh     = {{WORD_WIDTH{1'b0}}, r_wdata} << {off, 3'b000};

    // High word is merged straight from the ACC1 read, low word from ACC0
    assign lo_src = (state == ACC0) ? mem_rd_data : lo_buf;
    assign rd_cat = {mem_rd_data, lo_src};
    assign rd_sh  = WORD_WIDTH'(rd_cat >> {off, 3'b000});

    // Truncate merged load data to its size, then sign- or zero-extend
    always_comb begin
        load_val = rd_sh;
        unique case (r_size)
            2'b00: load_val = r_uns ?
                {{(WORD_WIDTH-8){1'b0}}, rd_sh[7:0]} :
                {{(WORD_WIDTH-8){rd_sh[7]}}, rd_sh[7:0]};
            2'b01: load_val = r_uns ?
                {{(WORD_WIDTH-16){1'b0}}, rd_sh[15:0]} :
                {{(WORD_WIDTH-16){rd_sh[15]}}, rd_sh[15:0]};
            default: load_val = rd_sh;
        endcase
    end

    // Memory port is driven only in the access states
    always_comb begin
        mem_adrs    = '0;
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_byt_en  = 4'b0000;
        mem_wr_data = '0;
        unique case (state)
            ACC0: begin
                mem_adrs    = word0;
                mem_rden    = !r_we;
                mem_wren    = r_we;
                mem_byt_en  = lane_mask[3:0];
                mem_wr_data = wr_sh[WORD_WIDTH-1:0];
            end
            ACC1: begin
                mem_adrs    = word1;
                mem_rden    = !r_we;
                mem_wren    = r_we;
                mem_byt_en  = lane_mask[7:4];
                mem_wr_data = wr_sh[2*WORD_WIDTH-1:WORD_WIDTH];
            end
            default: ;
        endcase
    end

    assign mem_sign_ext = 1'b0;
    assign req_ready    = rst_n && (state == IDLE);
    assign resp_valid   = (state == RESP);

    // Request capture, access sequencing and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_adrs     <= '0;
            r_wdata    <= '0;
            lo_buf     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_adrs  <= req_adrs;
                        r_wdata <= req_wdata;
                        if (in_err) begin
                            state      <= RESP;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (!r_we) lo_buf <= mem_rd_data;
                    if (r_cross) begin
                        state <= ACC1;
                    end else begin
                        state      <= RESP;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_we ? '0 : load_val;
                    end
                end
                ACC1: begin
                    state      <= RESP;
                    resp_err   <= 1'b0;
                    resp_rdata <= r_we ? '0 : load_val;
                end
                default: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                    end
                end
            endcase
        end
    end

endmodule
